fetch_queue: RTL

//  Instruction fetch stage: owns the PC, issues 16-bit reads to instruction memory, and buffers returned words.

---
 rtl/fetch_queue.sv | 109 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner, single-outstanding imem reader and DEPTH-entry instruction queue to decode.
// Define FETCH_ALIGN_CHECK_EN to flag odd redirect/reset PCs with sticky Err and halt.
module fetch_queue #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ImemReq,
   output logic [15:0] ImemAddr,
   input  logic        ImemAck,
   input  logic [15:0] ImemRdata,
   output logic [15:0] Instr,
   output logic [15:0] PcPlus2,
   output logic        InstrValid,
   input  logic        InstrReady,
   input  logic        Redirect,
   input  logic [15:0] RedirectPc,
   input  logic        Halt,
   output logic        Err
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   typedef enum logic [1:0] {IDLE, WAIT, DROP, HALTED} state_t;
   state_t r_state, w_state;
   logic [15:0] r_pc, w_pc, w_rpc;
   logic [15:0] r_qi [DEPTH];
   logic [15:0] r_qp [DEPTH];
   logic [PW-1:0] r_rd, r_wr;
   logic [CW-1:0] r_cnt, w_cnt;
   logic r_halt, w_live, w_ack, w_pop, w_push, w_fault, w_stop, w_flush, w_redir, w_pend, w_issue;
`ifdef FETCH_ALIGN_CHECK_EN
   localparam logic [15:0] RST_PC = RESET_PC;
   logic r_err, r_boot;
   assign w_rpc   = RedirectPc;
   assign w_fault = (Redirect & RedirectPc[0]) | (r_boot & RST_PC[0]);
   assign Err     = r_err;
   always_ff @(posedge clk)
      if (rst) begin
         r_err  <= 1'b0;
         r_boot <= 1'b1;
      end else begin
         r_boot <= 1'b0;
         r_err  <= r_err | (w_live & w_fault);
      end
`else
   localparam logic [15:0] RST_PC = {RESET_PC[15:1], 1'b0};
   assign w_rpc   = RedirectPc & 16'hFFFE;
   assign w_fault = 1'b0;
   assign Err     = 1'b0;
`endif
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction
   assign w_live  = r_state != HALTED;
   assign w_ack   = ImemReq & ImemAck;
   assign w_pend  = ImemReq & ~ImemAck;
   assign w_pop   = InstrValid & InstrReady;
   assign w_stop  = w_live & (Halt | w_fault);
   assign w_flush = w_stop | (w_live & Redirect);
   assign w_redir = w_live & Redirect & ~w_stop;
   // only a live WAIT ack carries wanted data; DROP acks and flushed acks are discarded
   assign w_push  = w_ack & (r_state == WAIT) & ~w_flush;
   assign w_cnt   = w_flush ? '0 : r_cnt - CW'(w_pop) + CW'(w_push);
   assign w_issue = (w_cnt < CW'(DEPTH)) & ~(r_halt | w_stop);
   assign w_pc    = w_redir ? w_rpc : w_push ? r_pc + 16'd2 : r_pc;
   always_comb
      w_state = !w_live ? HALTED :
                w_pend ? (((r_state == WAIT) & ~w_flush) ? WAIT : DROP) :
                (r_halt | w_stop) ? HALTED :
                w_issue ? WAIT : IDLE;
   assign InstrValid = r_cnt != '0;
   assign Instr      = r_qi[r_rd];
   assign PcPlus2    = r_qp[r_rd];
   always_ff @(posedge clk)
      if (rst) begin
         r_state  <= IDLE;
         r_pc     <= RST_PC;
         r_halt   <= 1'b0;
         ImemReq  <= 1'b0;
         ImemAddr <= RST_PC;
         r_rd     <= '0;
         r_wr     <= '0;
         r_cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_qi[i] <= '0;
            r_qp[i] <= '0;
         end
      end else begin
         r_state <= w_state;
         r_pc    <= w_pc;
         r_halt  <= r_halt | w_stop;
         r_cnt   <= w_cnt;
         ImemReq <= (w_state == WAIT) | (w_state == DROP);
         // a pending request keeps its address; a fresh one takes the updated PC
         if (!w_pend && w_state == WAIT) ImemAddr <= w_pc;
         if (w_flush) begin
            r_rd <= '0;
            r_wr <= '0;
         end else begin
            if (w_pop) r_rd <= inc(r_rd);
            if (w_push) begin
               r_qi[r_wr] <= ImemRdata;
               r_qp[r_wr] <= ImemAddr + 16'd2;
               r_wr       <= inc(r_wr);
            end
         end
      end
endmodule
